// File: rtl/mxu_bus_if.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_bus_if
//  Description : Bundle of the core request/response handshake and the
//                Avalon-style memory master signals used by mxu_bus.
//                'master' is the view of the transfer unit itself, which
//                drives the bus strobes and the response. 'slave' is the
//                view of its surroundings: the core plus the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mxu_bus_if #(
  parameter int ADDR_WIDTH = 32
);
  // Core request
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_fetch;
  logic [6:0]            instcode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  // Core response
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;
  // Memory master port
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic [3:0]            avm_byteenable;
  logic [31:0]           avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    input  req_valid, req_fetch, instcode, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output req_valid, req_fetch, instcode, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface
`default_nettype wire

// File: rtl/mxu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_bus
//  Description : Sequential memory transfer unit. Accepts one core request at
//                a time, runs it as a single Avalon-style bus transaction
//                (honouring waitrequest, with an optional stall timeout),
//                places store data on the proper byte lanes and extracts /
//                merges load data (LB/LBU/LH/LHU/LW/LWL/LWR).
//                Optional feature: define MXU_BUS_ALIGN_CHECK_EN to reject
//                misaligned fetch/LW/SW/LH/LHU/SH with resp_error and no
//                bus cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mxu_bus #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic      clk,
  input  logic      reset,
  mxu_bus_if.master bus
);

  localparam logic [6:0] c_lb  = 7'd42;
  localparam logic [6:0] c_lbu = 7'd43;
  localparam logic [6:0] c_lh  = 7'd44;
  localparam logic [6:0] c_lhu = 7'd45;
  localparam logic [6:0] c_lw  = 7'd47;
  localparam logic [6:0] c_lwl = 7'd48;
  localparam logic [6:0] c_lwr = 7'd49;
  localparam logic [6:0] c_sb  = 7'd50;
  localparam logic [6:0] c_sh  = 7'd51;
  localparam logic [6:0] c_sw  = 7'd52;

  // Wide enough to hold TIMEOUT itself; the counter never goes beyond it.
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_bus  = 2'd1,
    st_resp = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [6:0]           w_code;
  logic [1:0]           w_o;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_misalign;
  logic                 w_to_bus;
  logic [3:0]           w_be;
  logic [31:0]          w_wd;

  logic [6:0]           r_code;
  logic [1:0]           r_o;
  logic [31:0]          r_rt;

  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic                 w_timeout;

  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;

  // A fetch behaves exactly like LW; instcode is don't-care then.
  assign w_code = bus.req_fetch ? c_lw : bus.instcode;
  assign w_o    = bus.req_addr[1:0];

  // Request decode: access class, lane enables, lane-replicated store data.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wd       = bus.req_wdata;
    case (w_code)
      c_lb, c_lbu, c_lh, c_lhu, c_lw, c_lwl, c_lwr: w_is_load = 1'b1;
      c_sb: begin
        w_is_store = 1'b1;
        w_be       = 4'b0001 << w_o;
        w_wd       = {4{bus.req_wdata[7:0]}};
      end
      c_sh: begin
        // Only bit 1 picks the half; an odd offset falls back to its even lane pair.
        w_is_store = 1'b1;
        w_be       = w_o[1] ? 4'b1100 : 4'b0011;
        w_wd       = {2{bus.req_wdata[15:0]}};
      end
      c_sw: w_is_store = 1'b1;
      default: ;
    endcase
`ifdef MXU_BUS_ALIGN_CHECK_EN
    case (w_code)
      c_lw, c_sw:        w_misalign = |w_o;
      c_lh, c_lhu, c_sh: w_misalign = w_o[0];
      default: ;
    endcase
`else
    w_misalign = 1'b0;
`endif
  end

  assign w_to_bus = (w_is_load || w_is_store) && !w_misalign;

  // Timeout fires on the stalled cycle that brings the count up to TIMEOUT.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && bus.avm_waitrequest &&
                     (w_cnt_inc == c_cnt_w'(TIMEOUT));

  assign bus.req_ready = (r_state == st_idle);

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      st_idle: if (bus.req_valid) w_state_next = w_to_bus ? st_bus : st_resp;
      st_bus:  if (!bus.avm_waitrequest || w_timeout) w_state_next = st_resp;
      st_resp: w_state_next = st_idle;
      default: w_state_next = st_idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= st_idle;
    else        r_state <= w_state_next;
  end

  // Load extraction from the zero-latency read data of the completing cycle.
  always_comb begin
    w_byte = bus.avm_readdata[7:0];
    case (r_o)
      2'd0: w_byte = bus.avm_readdata[7:0];
      2'd1: w_byte = bus.avm_readdata[15:8];
      2'd2: w_byte = bus.avm_readdata[23:16];
      2'd3: w_byte = bus.avm_readdata[31:24];
      default: ;
    endcase
    w_half = r_o[1] ? bus.avm_readdata[31:16] : bus.avm_readdata[15:0];
    w_load = 32'd0;
    case (r_code)
      c_lb:  w_load = {{24{w_byte[7]}}, w_byte};
      c_lbu: w_load = {24'd0, w_byte};
      c_lh:  w_load = {{16{w_half[15]}}, w_half};
      c_lhu: w_load = {16'd0, w_half};
      c_lw:  w_load = bus.avm_readdata;
      c_lwl: begin
        case (r_o)
          2'd0: w_load = {bus.avm_readdata[7:0],  r_rt[23:0]};
          2'd1: w_load = {bus.avm_readdata[15:0], r_rt[15:0]};
          2'd2: w_load = {bus.avm_readdata[23:0], r_rt[7:0]};
          default: w_load = bus.avm_readdata;
        endcase
      end
      c_lwr: begin
        case (r_o)
          2'd1: w_load = {r_rt[31:24], bus.avm_readdata[31:8]};
          2'd2: w_load = {r_rt[31:16], bus.avm_readdata[31:16]};
          2'd3: w_load = {r_rt[31:8],  bus.avm_readdata[31:24]};
          default: w_load = bus.avm_readdata;
        endcase
      end
      default: w_load = 32'd0;  // stores return zero
    endcase
  end

  // Request capture, bus strobes, timeout counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code             <= 7'd0;
      r_o                <= 2'd0;
      r_rt               <= 32'd0;
      r_cnt              <= '0;
      bus.avm_address    <= '0;
      bus.avm_read       <= 1'b0;
      bus.avm_write      <= 1'b0;
      bus.avm_writedata  <= 32'd0;
      bus.avm_byteenable <= 4'd0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= 32'd0;
      bus.resp_error     <= 1'b0;
    end else begin
      case (r_state)
        st_idle: begin
          if (bus.req_valid) begin
            r_code <= w_code;
            r_o    <= w_o;
            r_rt   <= bus.req_wdata;
            r_cnt  <= '0;
            if (w_to_bus) begin
              bus.avm_address    <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              bus.avm_read       <= w_is_load;
              bus.avm_write      <= w_is_store;
              bus.avm_writedata  <= w_wd;
              bus.avm_byteenable <= w_be;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= 32'd0;
              bus.resp_error <= w_misalign;
            end
          end
        end
        st_bus: begin
          if (!bus.avm_waitrequest) begin
            bus.avm_read   <= 1'b0;
            bus.avm_write  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= w_load;
            bus.resp_error <= 1'b0;
          end else if (w_timeout) begin
            bus.avm_read   <= 1'b0;
            bus.avm_write  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= 32'd0;
            bus.resp_error <= 1'b1;
          end else if (TIMEOUT != 0) begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= 32'd0;
          bus.resp_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mxu_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mxu_bus
//  Description : Self-checking bench for mxu_bus (TIMEOUT=4). A stalling
//                memory model answers the bus; expected responses are queued
//                when a request is driven and compared when it completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mxu_bus;

  localparam logic [6:0] LB = 7'd42, LBU = 7'd43, LH = 7'd44, LHU = 7'd45;
  localparam logic [6:0] LUI = 7'd46, LW = 7'd47, LWL = 7'd48, LWR = 7'd49;
  localparam logic [6:0] SB = 7'd50, SH = 7'd51, SW = 7'd52;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mxu_bus_if #(.ADDR_WIDTH(32)) bif ();

  mxu_bus #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  // Memory model: stalls the first stall_cfg strobe cycles of every access.
  int          stall_cfg = 0;
  logic [31:0] mem_word  = 32'd0;
  int          busy      = 0;
  always @(negedge clk) begin
    if (bif.avm_read || bif.avm_write) begin
      bif.avm_waitrequest = (busy < stall_cfg);
      busy++;
    end else begin
      bif.avm_waitrequest = 1'b0;
      busy = 0;
    end
    bif.avm_readdata = mem_word;
  end

  // Observations of the last transaction.
  int          obs_rd, obs_wr, obs_resp_k, obs_nresp;
  logic        obs_both, obs_unstable, obs_err;
  logic [31:0] obs_addr, obs_wd, obs_rdata;
  logic [3:0]  obs_be;

  function automatic logic [31:0] exp_load(input logic [6:0] c, input logic [1:0] o,
                                           input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] b, h;
    int sh;
    sh = 8 * int'(o);
    b  = (m >> sh) & 32'h000000FF;
    h  = (m >> (o[1] ? 16 : 0)) & 32'h0000FFFF;
    case (c)
      LB:  return b[7]  ? (b | 32'hFFFFFF00) : b;
      LBU: return b;
      LH:  return h[15] ? (h | 32'hFFFF0000) : h;
      LHU: return h;
      LW:  return m;
      LWL: return (m << (24 - sh)) | (rt & (32'hFFFFFFFF >> (sh + 8)));
      LWR: return (m >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [6:0] c, input logic [1:0] o);
    if (c == SB) return 4'(1 << o);
    if (c == SH) return o[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [6:0] c, input logic [31:0] w);
    if (c == SB) return {24'd0, w[7:0]} * 32'h01010101;
    if (c == SH) return {16'd0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  // Drive one request and record what the DUT does over the next 20 cycles.
  task automatic run_op(input logic fetch, input logic [6:0] code, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mem, input int stalls);
    obs_rd = 0; obs_wr = 0; obs_resp_k = -1; obs_nresp = 0;
    obs_both = 1'b0; obs_unstable = 1'b0; obs_err = 1'b0;
    obs_addr = '0; obs_wd = '0; obs_rdata = '0; obs_be = '0;
    stall_cfg = stalls;
    mem_word  = mem;
    @(negedge clk);
    bif.req_fetch = fetch;
    bif.instcode  = code;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_valid = 1'b1;
    for (int i = 0; i < 50 && !bif.req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    bif.req_addr  = 32'hFFFF_FFFF;
    bif.req_wdata = 32'h5A5A_5A5A;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bif.avm_read || bif.avm_write) begin
        if (obs_rd + obs_wr == 0) begin
          obs_addr = bif.avm_address;
          obs_be   = bif.avm_byteenable;
          obs_wd   = bif.avm_writedata;
        end else if (obs_addr !== bif.avm_address || obs_be !== bif.avm_byteenable ||
                     obs_wd !== bif.avm_writedata) begin
          obs_unstable = 1'b1;
        end
      end
      if (bif.avm_read)  obs_rd++;
      if (bif.avm_write) obs_wr++;
      if (bif.avm_read && bif.avm_write) obs_both = 1'b1;
      if (bif.resp_valid) begin
        obs_nresp++;
        if (obs_resp_k < 0) begin
          obs_resp_k = k;
          obs_rdata  = bif.resp_rdata;
          obs_err    = bif.resp_error;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (bif.avm_read !== 1'b0 || bif.avm_write !== 1'b0 || bif.resp_valid !== 1'b0 ||
        bif.resp_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset strobes: rd=%b wr=%b rv=%b re=%b, want all 0",
               bif.avm_read, bif.avm_write, bif.resp_valid, bif.resp_error);
    end
    vectors++;
    if (bif.avm_address !== 32'd0 || bif.avm_writedata !== 32'd0 ||
        bif.avm_byteenable !== 4'd0 || bif.resp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset data: addr=%h wd=%h be=%b rdata=%h, want all 0",
               bif.avm_address, bif.avm_writedata, bif.avm_byteenable, bif.resp_rdata);
    end
    vectors++;
    if (bif.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset ready: got %b, want 1", bif.req_ready);
    end
    bif.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bif.avm_read !== 1'b0 || bif.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset no_accept: rd=%b rv=%b, want 0 0", bif.avm_read, bif.resp_valid);
    end
  endtask

  task automatic test_loads();
    logic [6:0]  tcode [10] = '{SW, LB, LHU, LH, LBU, LWL, LWR, LWL, LWR, LW};
    logic [31:0] taddr [10] = '{32'hBFC00000, 32'h1003, 32'h1002, 32'h1000, 32'h1001,
                                32'h1001, 32'h1001, 32'h1003, 32'h1000, 32'h1008};
    logic [31:0] tmem  [10] = '{32'h3C011234, 32'h80FF00AA, 32'h80FF00AA, 32'h1234F00D,
                                32'h1234F00D, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD,
                                32'hAABBCCDD, 32'hCAFEBABE};
    int          tstall[10] = '{0, 0, 0, 1, 2, 0, 0, 1, 0, 0};
    logic [31:0] rt = 32'h11223344;
    logic [6:0]  c;
    logic        f;
    exp_t        e;
    for (int i = 0; i < 10; i++) begin
      f = (i == 0);
      c = f ? LW : tcode[i];
      e.rdata = exp_load(c, taddr[i][1:0], tmem[i], rt);
      e.err = 1'b0; e.lat = tstall[i] + 2; e.rd = tstall[i] + 1; e.wr = 0;
      sb.push_back(e);
      run_op(f, tcode[i], taddr[i], rt, tmem[i], tstall[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_resp_k !== e.lat || obs_nresp !== 1) begin
        miscompares++;
        $display("FAIL load[%0d] latency: got %0d (%0d resp), want %0d (1 resp)",
                 i, obs_resp_k, obs_nresp, e.lat);
      end
      vectors++;
      if (obs_rdata !== e.rdata || obs_err !== e.err) begin
        miscompares++;
        $display("FAIL load[%0d] rdata: got %h err=%b, want %h err=%b",
                 i, obs_rdata, obs_err, e.rdata, e.err);
      end
      vectors++;
      if (obs_rd !== e.rd || obs_wr !== e.wr || obs_both) begin
        miscompares++;
        $display("FAIL load[%0d] strobes: rd=%0d wr=%0d, want rd=%0d wr=%0d",
                 i, obs_rd, obs_wr, e.rd, e.wr);
      end
      vectors++;
      if (obs_addr !== {taddr[i][31:2], 2'b00} || obs_be !== 4'b1111 || obs_unstable) begin
        miscompares++;
        $display("FAIL load[%0d] bus: addr=%h be=%b unstable=%b, want %h 1111 0",
                 i, obs_addr, obs_be, obs_unstable, {taddr[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_stores_stall();
    logic [6:0]  tcode [3] = '{SB, SH, SW};
    logic [31:0] taddr [3] = '{32'h2001, 32'h2002, 32'h2004};
    logic [31:0] twd   [3] = '{32'h000000C5, 32'hBEEF1234, 32'hDEADBEEF};
    int          tstall[3] = '{3, 0, 1};
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'd0; e.err = 1'b0; e.lat = tstall[i] + 2; e.rd = 0; e.wr = tstall[i] + 1;
      sb.push_back(e);
      run_op(1'b0, tcode[i], taddr[i], twd[i], 32'h99999999, tstall[i]);
      e = sb.pop_front();
      vectors++;
      if (obs_resp_k !== e.lat || obs_nresp !== 1 || obs_rdata !== e.rdata || obs_err !== e.err) begin
        miscompares++;
        $display("FAIL store[%0d] resp: k=%0d n=%0d rdata=%h err=%b, want k=%0d n=1 rdata=0 err=0",
                 i, obs_resp_k, obs_nresp, obs_rdata, obs_err, e.lat);
      end
      vectors++;
      if (obs_wr !== e.wr || obs_rd !== e.rd || obs_both || obs_unstable) begin
        miscompares++;
        $display("FAIL store[%0d] strobes: wr=%0d rd=%0d unstable=%b, want wr=%0d rd=0 stable",
                 i, obs_wr, obs_rd, obs_unstable, e.wr);
      end
      vectors++;
      if (obs_be !== exp_be(tcode[i], taddr[i][1:0]) || obs_wd !== exp_wd(tcode[i], twd[i]) ||
          obs_addr !== {taddr[i][31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL store[%0d] lanes: be=%b wd=%h addr=%h, want be=%b wd=%h addr=%h",
                 i, obs_be, obs_wd, obs_addr, exp_be(tcode[i], taddr[i][1:0]),
                 exp_wd(tcode[i], twd[i]), {taddr[i][31:2], 2'b00});
      end
    end
  endtask

  task automatic test_nonmem();
    logic [6:0] tcode [2] = '{LUI, 7'd99};
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      e.rdata = 32'd0; e.err = 1'b0; e.lat = 1; e.rd = 0; e.wr = 0;
      sb.push_back(e);
      run_op(1'b0, tcode[i], 32'h10, 32'h12345678, 32'hFFFFFFFF, 0);
      e = sb.pop_front();
      vectors++;
      if (obs_resp_k !== e.lat || obs_nresp !== 1 || obs_rdata !== e.rdata || obs_err !== e.err ||
          obs_rd !== 0 || obs_wr !== 0) begin
        miscompares++;
        $display("FAIL nonmem[%0d]: k=%0d n=%0d rdata=%h err=%b rd=%0d wr=%0d, want k=1 n=1 0 0 0 0",
                 i, obs_resp_k, obs_nresp, obs_rdata, obs_err, obs_rd, obs_wr);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    e.rdata = 32'd0; e.err = 1'b1; e.lat = 5; e.rd = 4; e.wr = 0;
    sb.push_back(e);
    run_op(1'b0, LW, 32'h500, 32'd0, 32'h77777777, 1000);
    e = sb.pop_front();
    vectors++;
    if (obs_rd !== e.rd || obs_resp_k !== e.lat || obs_nresp !== 1) begin
      miscompares++;
      $display("FAIL timeout timing: rd=%0d k=%0d n=%0d, want rd=4 k=5 n=1",
               obs_rd, obs_resp_k, obs_nresp);
    end
    vectors++;
    if (obs_err !== e.err || obs_rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL timeout resp: err=%b rdata=%h, want err=1 rdata=0", obs_err, obs_rdata);
    end
  endtask

  task automatic test_reset_midbus();
    int seen;
    stall_cfg = 1000;
    mem_word  = 32'h13579BDF;
    @(negedge clk);
    bif.req_fetch = 1'b0; bif.instcode = LW; bif.req_addr = 32'h40; bif.req_valid = 1'b1;
    @(posedge clk);
    #1 bif.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bif.avm_read !== 1'b1) begin
      miscompares++;
      $display("FAIL midbus pre: avm_read=%b, want 1", bif.avm_read);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bif.avm_read !== 1'b0 || bif.avm_write !== 1'b0 || bif.resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midbus reset: rd=%b wr=%b rv=%b, want 0 0 0",
               bif.avm_read, bif.avm_write, bif.resp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    stall_cfg = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bif.resp_valid || bif.avm_read || bif.avm_write) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midbus after: %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_align();
    logic [6:0]  tcode [3] = '{LW, SH, LH};
    logic [31:0] taddr [3] = '{32'h3002, 32'h2001, 32'h1003};
    logic [31:0] mem = 32'h80FF00AA;
    logic [31:0] wd  = 32'h0000ABCD;
    logic        st;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      st = (tcode[i] == SH);
`ifdef MXU_BUS_ALIGN_CHECK_EN
      e.rdata = 32'd0; e.err = 1'b1; e.lat = 1; e.rd = 0; e.wr = 0;
`else
      // Misaligned low bits are ignored for lane selection.
      e.rdata = st ? 32'd0 : exp_load(tcode[i], {taddr[i][1], 1'b0}, mem, wd);
      e.err = 1'b0; e.lat = 2; e.rd = st ? 0 : 1; e.wr = st ? 1 : 0;
`endif
      sb.push_back(e);
      run_op(1'b0, tcode[i], taddr[i], wd, mem, 0);
      e = sb.pop_front();
      vectors++;
      if (obs_resp_k !== e.lat || obs_nresp !== 1 || obs_rdata !== e.rdata || obs_err !== e.err) begin
        miscompares++;
        $display("FAIL align[%0d] resp: k=%0d n=%0d rdata=%h err=%b, want k=%0d n=1 rdata=%h err=%b",
                 i, obs_resp_k, obs_nresp, obs_rdata, obs_err, e.lat, e.rdata, e.err);
      end
      vectors++;
      if (obs_rd !== e.rd || obs_wr !== e.wr ||
          (e.rd + e.wr > 0 && (obs_addr !== {taddr[i][31:2], 2'b00} ||
                               obs_be !== (st ? 4'b0011 : 4'b1111)))) begin
        miscompares++;
        $display("FAIL align[%0d] bus: rd=%0d wr=%0d addr=%h be=%b, want rd=%0d wr=%0d addr=%h",
                 i, obs_rd, obs_wr, obs_addr, obs_be, e.rd, e.wr, {taddr[i][31:2], 2'b00});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.req_valid = 1'b1;
    bif.req_fetch = 1'b0;
    bif.instcode  = LW;
    bif.req_addr  = 32'h0000_0100;
    bif.req_wdata = 32'd0;
    test_reset();
    test_loads();
    test_stores_stall();
    test_nonmem();
    test_timeout();
    test_reset_midbus();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mxu_bus.md
# mxu_bus

- Parametrised, sequential successor to the combinational memory transfer unit.
- Sits between the CPU core and the Avalon-style memory master port. It serialises instruction fetches and data accesses into single bus transactions and honours `avm_waitrequest`.
- Generates byte enables, places store data on the correct byte lanes, and performs load extraction: LB/LBU/LH/LHU sign/zero extension and LWL/LWR merge.
- Reports completion, and optionally errors, to the core through a valid/ready handshake.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, width of request and bus addresses.
- `TIMEOUT`, 255, maximum consecutive `avm_waitrequest` cycles before a bus error; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_fetch` in 1: 1 = instruction fetch (treated as LW, `instcode` ignored).
- `instcode` in 7: LB=42, LBU=43, LH=44, LHU=45, LUI=46, LW=47, LWL=48, LWR=49, SB=50, SH=51, SW=52.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data for stores; current rt value for LWL/LWR.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 for stores.
- `resp_error` out 1: qualifies `resp_valid`; access failed.
- `avm_address` out ADDR_WIDTH: word-aligned address, low 2 bits always 0.
- `avm_read` out 1: bus read strobe.
- `avm_write` out 1: bus write strobe.
- `avm_writedata` out 32: bus write data.
- `avm_byteenable` out 4: bus byte lane enables.
- `avm_readdata` in 32: bus read data.
- `avm_waitrequest` in 1: bus stall.

## Operation

State machine:
- IDLE -> BUS: on accept of a memory op.
- IDLE -> RESP: on accept of LUI, any code not listed, or an alignment error.
- BUS -> RESP: when `avm_waitrequest`=0, or on timeout.
- RESP -> IDLE: always.

Request capture:
- All request fields are registered on accept.
- `req_*` inputs are ignored outside IDLE.

Byte lanes (little-endian, o = `addr[1:0]`):
- Loads and fetch: `avm_byteenable`=4'b1111.
- SB: byteenable = 1<<o; writedata = byte replicated to all 4 lanes.
- SH: o=0 -> 4'b0011, o=2 -> 4'b1100; writedata = halfword replicated.
- SW: 4'b1111, data unchanged.

Load results:
- LB/LBU: byte at lane o, sign-/zero-extended.
- LH/LHU: halfword at lanes o..o+1, sign-/zero-extended.
- LW/fetch: full word.
- LWL: (mem << 8*(3-o)) | (rt & (32'hFFFFFFFF >> 8*(o+1))).
- LWR: (mem >> 8*o) | (rt & ~(32'hFFFFFFFF >> 8*o)).
- o=3 LWL and o=0 LWR each return the full word.

Non-memory codes (LUI, unlisted):
- No bus cycle.
- `resp_valid`=1, `resp_rdata`=0, `resp_error`=0.

Bus strobes:
- `avm_read`/`avm_write` are asserted for the whole of BUS and are never both high.
- Address, data and byteenable are held stable while `avm_waitrequest`=1.

Timeout:
- Counter clears on entering BUS and increments on each stalled cycle.
- When it equals TIMEOUT (TIMEOUT>0), strobes drop on the next edge and RESP is entered with `resp_error`=1 and `resp_rdata`=0.

## Timing

Reset:
- Asynchronous and active-low; takes effect immediately, including mid-transaction.
- State returns to IDLE.
- `avm_read`, `avm_write`, `resp_valid`, `resp_error` = 0.
- `avm_address`, `avm_writedata`, `resp_rdata` = 0; `avm_byteenable` = 0.
- `req_ready` = 1 (decoded from IDLE), but no accept occurs while reset is low.
- An aborted bus transaction produces no response.

Latency:
- Accept at edge N; strobes high in cycle N+1.
- With `avm_waitrequest`=0 in N+1, `avm_readdata` is sampled at edge N+2 and `resp_valid` is high in cycle N+2.
- Each stalled cycle adds one cycle.
- No-bus responses: `resp_valid` high in cycle N+1.

Throughput:
- Next accept is earliest in the cycle after RESP.
- Minimum 3 cycles per bus access.

Other:
- The response is not back-pressured; the core must consume `resp_valid` in its cycle.
- Readdata is zero-latency: valid in the cycle where `avm_waitrequest`=0.

## Configuration

`MXU_BUS_ALIGN_CHECK_EN`:
- Defined: misaligned fetch/LW/SW (`addr[1:0]`≠0) or LH/LHU/SH (`addr[0]`=1) issues no bus cycle. The block goes IDLE -> RESP with `resp_error`=1 and `resp_rdata`=0. LB/LBU/SB/LWL/LWR are never misaligned.
- Undefined: no check. Offending low address bits are treated as 0 for lane selection (SH at o=1 uses 4'b0011; LH at o=3 uses lanes 2..3), and `resp_error` is driven only by the timeout.

## Test plan

- **Fetch:** fetch at 0xBFC00000, waitrequest low, readdata 0x3C011234 -> `avm_read` one cycle at 0xBFC00000, byteenable 1111; `resp_rdata`=0x3C011234 two cycles after accept.
- **LB and LHU:** LB at 0x1003 with readdata 0x80FF00AA -> 0xFFFFFF80. LHU at 0x1002 with readdata 0x80FF00AA -> 0x000080FF.
- **Stores with stall:** SB at 0x2001, wdata 0x000000C5, 3 waitrequest cycles -> byteenable 0010, writedata 0xC5C5C5C5 held 4 cycles, `resp_valid` on the following cycle. SH at 0x2002 -> byteenable 1100.
- **LWL/LWR merge:** rt 0x11223344, mem 0xAABBCCDD. LWL o=1 -> 0xCCDD3344. LWR o=1 -> 0x11AABBCC.
- **Timeout and reset:** TIMEOUT=4 with waitrequest stuck high -> strobes drop after 4 stalled cycles, `resp_error`=1. Separately, reset pulsed low mid-BUS -> strobes 0 immediately, no `resp_valid`.
- **Alignment check:** with `MXU_BUS_ALIGN_CHECK_EN`, LW at 0x3002 -> no strobe, `resp_valid`+`resp_error` one cycle after accept. Without it -> normal read at 0x3000.
